// File: rtl/calc_pkg.sv
// Shared calculator types and constants: UART TX FSM states, ASCII codes, result widths.
package calc_pkg;

   localparam int unsigned RES_W       = 9;
   localparam int unsigned BCD_W       = 4;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned FRAME_SLOTS = 8;

   typedef enum logic [1:0] {TX_IDLE, TX_CONVERT, TX_SEND, TX_GAP} tx_state_e;

   typedef struct packed {
      logic sign;
      logic o_flag;
   } res_flags_t;

   localparam logic [BYTE_W-1:0] ASC_PLUS  = 8'h2B;
   localparam logic [BYTE_W-1:0] ASC_MINUS = 8'h2D;
   localparam logic [BYTE_W-1:0] ASC_ZERO  = 8'h30;
   localparam logic [BYTE_W-1:0] ASC_E     = 8'h45;
   localparam logic [BYTE_W-1:0] ASC_CR    = 8'h0D;
   localparam logic [BYTE_W-1:0] ASC_LF    = 8'h0A;

   function automatic logic [BYTE_W-1:0] asc_digit(input logic [BCD_W-1:0] d);
      return ASC_ZERO + BYTE_W'(d);
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD (shift-add-3); the first shift happens on start,
// so digits are valid 9 cycles after start, flagged by a one-cycle done pulse.
module bin2bcd_seq
   import calc_pkg::*;
(
   input  logic               hwclk,
   input  logic               reset,
   input  logic               start,
   input  logic [RES_W-1:0]   bin,
   output logic [BCD_W-1:0]   hundreds,
   output logic [BCD_W-1:0]   tens,
   output logic [BCD_W-1:0]   units,
   output logic               done
);

   localparam int unsigned SR_W  = 3 * BCD_W + RES_W;
   localparam int unsigned CNT_W = 4;

   logic [SR_W-1:0]  sr_q, sr_d, adj_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      sr_d   = sr_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      adj_c  = sr_q;
      for (int i = 0; i < 3; i++) begin
         if (adj_c[RES_W + BCD_W*i +: BCD_W] >= 4'd5)
            adj_c[RES_W + BCD_W*i +: BCD_W] = adj_c[RES_W + BCD_W*i +: BCD_W] + 4'd3;
      end
      if (start) begin
         sr_d  = SR_W'({bin, 1'b0});
         cnt_d = CNT_W'(RES_W - 1);
      end else if (cnt_q != '0) begin
         sr_d   = {adj_c[SR_W-2:0], 1'b0};
         cnt_d  = cnt_q - CNT_W'(1);
         done_d = (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge hwclk) begin
      if (reset) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         sr_q   <= sr_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign hundreds = sr_q[SR_W-1         -: BCD_W];
   assign tens     = sr_q[SR_W-1-BCD_W   -: BCD_W];
   assign units    = sr_q[SR_W-1-2*BCD_W -: BCD_W];
   assign done     = done_q;

endmodule

// File: rtl/result_uart_tx.sv
// Streams each ALU result as an ASCII line ("-042\r\n") to the byte-wide UART,
// one txclk strobe per byte with a one-cycle gap between bytes.
module result_uart_tx
   import calc_pkg::*;
#(
   parameter bit LEAD_ZEROS = 1'b1,
   parameter bit EOL_CRLF   = 1'b1
)
(
   input  logic              hwclk,
   input  logic              reset,
   input  logic              result_ready,
   input  logic [RES_W-1:0]  result,
   input  logic              sign,
   input  logic              o_flag,
   input  logic              txready,
   output logic [BYTE_W-1:0] txdata,
   output logic              txclk,
   output logic              busy,
   output logic              overrun
);

   tx_state_e          state_q, state_d;
   res_flags_t         flags_q, flags_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BYTE_W-1:0]  txdata_q, txdata_d;
   logic               txclk_q, txclk_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;

   logic               conv_start_c, conv_done;
   logic [BCD_W-1:0]   hundreds, tens, units;
   logic [BYTE_W-1:0]  frame_c [FRAME_SLOTS];
   logic [IDX_W-1:0]   len_c;

   // The converter samples the raw result on the accepting strobe itself.
   assign conv_start_c = (state_q == TX_IDLE) && result_ready;

   bin2bcd_seq u_bcd (
      .hwclk    (hwclk),
      .reset    (reset),
      .start    (conv_start_c),
      .bin      (result),
      .hundreds (hundreds),
      .tens     (tens),
      .units    (units),
      .done     (conv_done)
   );

   // Frame builder: len_c doubles as the append pointer while the frame is assembled.
   always_comb begin
      for (int i = 0; i < int'(FRAME_SLOTS); i++) frame_c[i] = '0;
      len_c = '0;
      frame_c[len_c] = flags_q.sign ? ASC_MINUS : ASC_PLUS;
      len_c = len_c + IDX_W'(1);
      if (LEAD_ZEROS || (hundreds != '0)) begin
         frame_c[len_c] = asc_digit(hundreds);
         len_c = len_c + IDX_W'(1);
      end
      if (LEAD_ZEROS || (hundreds != '0) || (tens != '0)) begin
         frame_c[len_c] = asc_digit(tens);
         len_c = len_c + IDX_W'(1);
      end
      frame_c[len_c] = asc_digit(units);
      len_c = len_c + IDX_W'(1);
      if (flags_q.o_flag) begin
         frame_c[len_c] = ASC_E;
         len_c = len_c + IDX_W'(1);
      end
      if (EOL_CRLF) begin
         frame_c[len_c] = ASC_CR;
         len_c = len_c + IDX_W'(1);
      end
      frame_c[len_c] = ASC_LF;
      len_c = len_c + IDX_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      flags_d   = flags_q;
      idx_d     = idx_q;
      txdata_d  = txdata_q;
      txclk_d   = 1'b0;
      overrun_d = overrun_q;
      case (state_q)
         TX_IDLE: begin
            if (result_ready) begin
               flags_d.sign   = sign;
               flags_d.o_flag = o_flag;
               idx_d          = '0;
               overrun_d      = 1'b0;
               state_d        = TX_CONVERT;
            end
         end
         TX_CONVERT: begin
            if (conv_done) state_d = TX_SEND;
         end
         TX_SEND: begin
            if (txready) begin
               txdata_d = frame_c[idx_q];
               txclk_d  = 1'b1;
               idx_d    = idx_q + IDX_W'(1);
               state_d  = TX_GAP;
            end
         end
         TX_GAP: begin
            state_d = (idx_q == len_c) ? TX_IDLE : TX_SEND;
         end
         default: state_d = TX_IDLE;
      endcase
      if (result_ready && (state_q != TX_IDLE)) overrun_d = 1'b1;
      busy_d = (state_d != TX_IDLE);
   end

   always_ff @(posedge hwclk) begin
      if (reset) begin
         state_q   <= TX_IDLE;
         flags_q   <= '0;
         idx_q     <= '0;
         txdata_q  <= '0;
         txclk_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         idx_q     <= idx_d;
         txdata_q  <= txdata_d;
         txclk_q   <= txclk_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   assign txdata  = txdata_q;
   assign txclk   = txclk_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed + randomized bench for result_uart_tx; three parameter variants share stimulus
// and every transferred byte is compared against frames built from decimal arithmetic.
module tb_result_uart_tx;

   logic       hwclk, reset, result_ready, sign, o_flag, txready;
   logic [8:0] result;
   logic [7:0] a_txdata, b_txdata, c_txdata;
   logic       a_txclk, b_txclk, c_txclk;
   logic       a_busy, b_busy, c_busy;
   logic       a_overrun, b_overrun, c_overrun;

   result_uart_tx #(.LEAD_ZEROS(1'b1), .EOL_CRLF(1'b1)) dut_a (
      .hwclk(hwclk), .reset(reset), .result_ready(result_ready), .result(result),
      .sign(sign), .o_flag(o_flag), .txready(txready), .txdata(a_txdata),
      .txclk(a_txclk), .busy(a_busy), .overrun(a_overrun));

   result_uart_tx #(.LEAD_ZEROS(1'b0), .EOL_CRLF(1'b1)) dut_b (
      .hwclk(hwclk), .reset(reset), .result_ready(result_ready), .result(result),
      .sign(sign), .o_flag(o_flag), .txready(txready), .txdata(b_txdata),
      .txclk(b_txclk), .busy(b_busy), .overrun(b_overrun));

   result_uart_tx #(.LEAD_ZEROS(1'b1), .EOL_CRLF(1'b0)) dut_c (
      .hwclk(hwclk), .reset(reset), .result_ready(result_ready), .result(result),
      .sign(sign), .o_flag(o_flag), .txready(txready), .txdata(c_txdata),
      .txclk(c_txclk), .busy(c_busy), .overrun(c_overrun));

   initial hwclk = 1'b0;
   always #5 hwclk = ~hwclk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         stall_left = 0;
   bit         rnd_ready  = 0;
   int         a_first, a_last, a_gap_bad;
   logic [7:0] qa[$], qb[$], qc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic [7:0] q[$]);
      logic [63:0] r = '0;
      foreach (q[i]) r = (r << 8) | 64'(q[i]);
      r[63:56] = 8'(q.size());
      return r;
   endfunction

   // Reference frame from plain decimal arithmetic.
   function automatic logic [63:0] model(input int v, input bit s, input bit o,
                                         input bit lz, input bit crlf);
      logic [7:0] q[$];
      int h = v / 100;
      int t = (v / 10) % 10;
      int u = v % 10;
      q.push_back(s ? 8'h2D : 8'h2B);
      if (lz || v >= 100) q.push_back(8'h30 + 8'(h));
      if (lz || v >= 10)  q.push_back(8'h30 + 8'(t));
      q.push_back(8'h30 + 8'(u));
      if (o)    q.push_back(8'h45);
      if (crlf) q.push_back(8'h0D);
      q.push_back(8'h0A);
      return pack(q);
   endfunction

   // One clock: sample outputs after the edge, choose txready for the coming cycle, log transfers.
   task automatic tick();
      @(posedge hwclk);
      #1;
      cyc++;
      if (a_txclk || b_txclk || c_txclk) txready = 1'b1;
      else if (stall_left > 0) begin
         txready = 1'b0;
         stall_left--;
      end else if (rnd_ready) txready = ($urandom_range(3) != 0);
      else txready = 1'b1;
      if (a_txclk && txready) begin
         if (qa.size() > 0 && (cyc - a_last) != 2) a_gap_bad++;
         if (qa.size() == 0) a_first = cyc;
         a_last = cyc;
         qa.push_back(a_txdata);
      end
      if (b_txclk && txready) qb.push_back(b_txdata);
      if (c_txclk && txready) qc.push_back(c_txdata);
   endtask

   task automatic strobe(input int v, input bit s, input bit o);
      result = 9'(v);
      sign = s;
      o_flag = o;
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while ((a_busy || b_busy || c_busy) && k < 3000) begin
         tick();
         k++;
      end
      chk({tag, "_idle"}, 64'(a_busy | b_busy | c_busy), 64'd0);
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int k = 0;
      while (qa.size() < n && k < 500) begin
         tick();
         k++;
      end
      chk({tag, "_bytes"}, 64'(qa.size() >= n), 64'd1);
   endtask

   task automatic check_frames(input string tag, input int v, input bit s, input bit o);
      chk({tag, "_a"}, pack(qa), model(v, s, o, 1'b1, 1'b1));
      chk({tag, "_b"}, pack(qb), model(v, s, o, 1'b0, 1'b1));
      chk({tag, "_c"}, pack(qc), model(v, s, o, 1'b1, 1'b0));
      qa.delete();
      qb.delete();
      qc.delete();
   endtask

   initial begin
      int t0, stall_bad;
      reset = 1'b1;
      result_ready = 1'b0;
      result = '0;
      sign = 1'b0;
      o_flag = 1'b0;
      txready = 1'b1;
      a_first = 0;
      a_last = 0;
      a_gap_bad = 0;

      // Reset state
      tick();
      tick();
      chk("rst_txdata", 64'(a_txdata), 64'h00);
      chk("rst_txclk",  64'(a_txclk | b_txclk | c_txclk), 64'd0);
      chk("rst_busy",   64'(a_busy | b_busy | c_busy), 64'd0);
      chk("rst_overrun", 64'(a_overrun | b_overrun | c_overrun), 64'd0);
      reset = 1'b0;
      tick();

      // 1: -42, txready high, exact timing
      t0 = cyc;
      a_gap_bad = 0;
      strobe(42, 1'b1, 1'b0);
      chk("t1_busy_rise", 64'(a_busy), 64'd1);
      wait_idle("t1");
      chk("t1_latency", 64'(a_first - t0), 64'd11);
      chk("t1_spacing", 64'(a_gap_bad), 64'd0);
      chk("t1_idle_cycle", 64'(cyc - t0), 64'd22);
      check_frames("t1_frame", 42, 1'b1, 1'b0);

      // 2: maximum with overflow, small values for leading-zero suppression
      strobe(511, 1'b0, 1'b1);
      wait_idle("t2_511");
      check_frames("t2_511", 511, 1'b0, 1'b1);
      strobe(7, 1'b0, 1'b0);
      wait_idle("t2_7");
      check_frames("t2_7", 7, 1'b0, 1'b0);
      strobe(0, 1'b0, 1'b0);
      wait_idle("t2_0");
      check_frames("t2_0", 0, 1'b0, 1'b0);
      strobe(0, 1'b1, 1'b0);
      wait_idle("t2_neg0");
      check_frames("t2_neg0", 0, 1'b1, 1'b0);

      // 3: stall for 20 cycles after the second byte
      strobe(123, 1'b0, 1'b0);
      wait_bytes(2, "t3");
      stall_left = 20;
      stall_bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (a_txclk !== 1'b0 || a_txdata !== 8'h31) stall_bad++;
      end
      chk("t3_stall_hold", 64'(stall_bad), 64'd0);
      chk("t3_still_busy", 64'(a_busy), 64'd1);
      wait_idle("t3");
      check_frames("t3_frame", 123, 1'b0, 1'b0);

      // 4: overrun during SEND, then clean acceptance clears it
      strobe(305, 1'b1, 1'b1);
      wait_bytes(1, "t4");
      strobe(77, 1'b0, 1'b0);
      chk("t4_overrun_set", 64'({a_overrun, b_overrun, c_overrun}), 64'b111);
      wait_idle("t4");
      check_frames("t4_frame", 305, 1'b1, 1'b1);
      chk("t4_overrun_sticky", 64'(a_overrun), 64'd1);
      strobe(77, 1'b0, 1'b0);
      chk("t4_overrun_clr", 64'(a_overrun), 64'd0);
      wait_idle("t4b");
      check_frames("t4b_frame", 77, 1'b0, 1'b0);

      // Strobe landing in the final GAP cycle of dut_a is ignored
      strobe(9, 1'b0, 1'b0);
      wait_bytes(6, "gap");
      strobe(500, 1'b1, 1'b0);
      chk("gap_overrun", 64'(a_overrun), 64'd1);
      wait_idle("gap");
      chk("gap_frame_a", pack(qa), model(9, 1'b0, 1'b0, 1'b1, 1'b1));
      qa.delete();
      qb.delete();
      qc.delete();

      // 5: reset mid-frame (with a simultaneous strobe), then a fresh frame
      strobe(256, 1'b1, 1'b0);
      wait_bytes(1, "t5");
      strobe(1, 1'b0, 1'b0);
      wait_bytes(3, "t5b");
      reset = 1'b1;
      result_ready = 1'b1;
      tick();
      reset = 1'b0;
      result_ready = 1'b0;
      chk("t5_txclk",   64'(a_txclk), 64'd0);
      chk("t5_busy",    64'(a_busy), 64'd0);
      chk("t5_txdata",  64'(a_txdata), 64'h00);
      chk("t5_overrun", 64'(a_overrun), 64'd0);
      tick();
      tick();
      chk("t5_nothing_latched", 64'(a_busy | b_busy | c_busy), 64'd0);
      qa.delete();
      qb.delete();
      qc.delete();
      strobe(256, 1'b1, 1'b0);
      wait_idle("t5c");
      check_frames("t5_fresh", 256, 1'b1, 1'b0);

      // 6: every {sign,result} with random overflow flag and txready stalls
      rnd_ready = 1;
      for (int i = 0; i < 1024; i++) begin
         int  v = i % 512;
         bit  s = (i >= 512);
         bit  o = 1'($urandom_range(1));
         strobe(v, s, o);
         wait_idle("t6");
         check_frames("t6_frame", v, s, o);
         if ($urandom_range(3) == 0) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
